// File: rtl/parity_frame_rx_if.sv
// Serial receive bundle: strobed line in, captured word and flags out.
// master drives the line; slave is the receiver.
interface parity_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              bit_en;
    logic              rx_bit;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              parity_err_o;
    logic              frame_err_o;
    logic              busy_o;

    modport master (
        output bit_en, rx_bit,
        input  data_o, valid_o, parity_err_o,
        input  frame_err_o, busy_o
    );

    modport slave (
        input  bit_en, rx_bit,
        output data_o, valid_o, parity_err_o,
        output frame_err_o, busy_o
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Strobed serial frame receiver: start, DATA_W bits LSB first,
// parity, stop. Reports the word with parity and framing flags.
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    parity_frame_rx_if.slave   bus
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cnt;
    logic              acc;
    logic              perr;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
    logic              busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            acc     <= 1'b0;
            perr    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (!bus.rx_bit) begin
                            state  <= DATA;
                            cnt    <= '0;
                            acc    <= 1'b0;
                            busy_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg[cnt] <= bus.rx_bit;
                        acc        <= acc ^ bus.rx_bit;
                        cnt        <= cnt + CW'(1);
                        if (cnt == LAST)
                            state <= PARITY;
                    end
                    PARITY: begin
                        // 1 means the received parity disagrees
                        perr  <= acc ^ bus.rx_bit ^ PARITY_ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        // a 0 here is a framing error, never a start bit
                        data_q  <= shreg;
                        perr_q  <= perr;
                        ferr_q  <= ~bus.rx_bit;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.parity_err_o = perr_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: frame-level model with per-cycle
// compare on two instances (8-bit even, 5-bit odd).
module tb_parity_frame_rx;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   vcount8 = 0;

    always #5 clk = ~clk;

    parity_frame_rx_if #(.DATA_W(8)) b8 ();
    parity_frame_rx_if #(.DATA_W(5)) b5 ();

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    parity_frame_rx #(.DATA_W(5), .PARITY_ODD(1'b1)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (b5)
    );

    // frame-level expectations, indexed 0 = dut8, 1 = dut5
    logic        exp_valid [2];
    logic        exp_busy  [2];
    logic [31:0] exp_data  [2];
    logic        exp_perr  [2];
    logic        exp_ferr  [2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (b8.valid_o === 1'b1) vcount8++;
        chk("valid8", 32'(b8.valid_o), 32'(exp_valid[0]));
        chk("busy8", 32'(b8.busy_o), 32'(exp_busy[0]));
        chk("data8", 32'(b8.data_o), exp_data[0]);
        chk("perr8", 32'(b8.parity_err_o), 32'(exp_perr[0]));
        chk("ferr8", 32'(b8.frame_err_o), 32'(exp_ferr[0]));
        chk("valid5", 32'(b5.valid_o), 32'(exp_valid[1]));
        chk("busy5", 32'(b5.busy_o), 32'(exp_busy[1]));
        chk("data5", 32'(b5.data_o), exp_data[1]);
        chk("perr5", 32'(b5.parity_err_o), 32'(exp_perr[1]));
        chk("ferr5", 32'(b5.frame_err_o), 32'(exp_ferr[1]));
    end

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            exp_valid[s] = 1'b0;
            exp_busy[s]  = 1'b0;
            exp_data[s]  = '0;
            exp_perr[s]  = 1'b0;
            exp_ferr[s]  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_valid[0] = 1'b0;
        exp_valid[1] = 1'b0;
    endtask

    task automatic drive(input int sel, input logic en, input logic b);
        if (sel == 0) begin
            b8.bit_en = en;
            b8.rx_bit = b;
        end else begin
            b5.bit_en = en;
            b5.rx_bit = b;
        end
    endtask

    // strobes rx_bit=1 at random; receivers must stay idle
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1'($urandom), 1'b1);
            drive(1, 1'($urandom), 1'b1);
            tick();
        end
        drive(0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b1);
    endtask

    // sends the first nstr strobes of a frame, with 0..maxgap
    // bit_en=0 cycles before each strobe after the start bit
    task automatic send_frame(input int sel, input logic [31:0] data,
                              input logic pbit, input logic stop,
                              input int maxgap, input int nstr);
        int          w;
        logic        odd;
        logic [31:0] d;
        logic        bits[$];
        w   = (sel == 0) ? 8 : 5;
        odd = (sel == 1);
        d   = data & ((32'h1 << w) - 32'h1);
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) bits.push_back(d[i]);
        bits.push_back(pbit);
        bits.push_back(stop);
        for (int k = 0; k < nstr; k++) begin
            if (k > 0) begin
                int g;
                g = int'($urandom_range(maxgap, 0));
                for (int j = 0; j < g; j++) begin
                    drive(sel, 1'b0, 1'($urandom));
                    tick();
                end
            end
            drive(sel, 1'b1, bits[k]);
            tick();
            if (k == 0) exp_busy[sel] = 1'b1;
            if (k == w + 2) begin
                exp_busy[sel]  = 1'b0;
                exp_valid[sel] = 1'b1;
                exp_data[sel]  = d;
                exp_perr[sel]  = (^d) ^ pbit ^ odd;
                exp_ferr[sel]  = ~stop;
            end
        end
        drive(sel, 1'b0, 1'b1);
    endtask

    initial begin
        int v0;
        model_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b1);
        tick();
        tick();
        chk("rst_busy", 32'(b8.busy_o), 32'h0);
        chk("rst_data", 32'(b8.data_o), 32'h0);
        rst = 1'b0;
        idle(3);

        send_frame(0, 32'hA5, 1'b0, 1'b1, 0, 11);
        chk("a5_valid", 32'(b8.valid_o), 32'h1);
        chk("a5_data", 32'(b8.data_o), 32'hA5);
        chk("a5_perr", 32'(b8.parity_err_o), 32'h0);
        chk("a5_ferr", 32'(b8.frame_err_o), 32'h0);
        tick();
        chk("a5_pulse", 32'(b8.valid_o), 32'h0);
        chk("a5_hold", 32'(b8.data_o), 32'hA5);

        send_frame(0, 32'h01, 1'b0, 1'b1, 0, 11);
        chk("p01_data", 32'(b8.data_o), 32'h01);
        chk("p01_perr", 32'(b8.parity_err_o), 32'h1);
        chk("p01_ferr", 32'(b8.frame_err_o), 32'h0);
        idle(2);

        send_frame(0, 32'h3C, 1'b0, 1'b0, 0, 11);
        chk("f3c_data", 32'(b8.data_o), 32'h3C);
        chk("f3c_ferr", 32'(b8.frame_err_o), 32'h1);
        send_frame(0, 32'h5A, 1'b0, 1'b1, 0, 11);
        chk("b5a_data", 32'(b8.data_o), 32'h5A);
        chk("b5a_perr", 32'(b8.parity_err_o), 32'h0);
        chk("b5a_ferr", 32'(b8.frame_err_o), 32'h0);
        idle(2);

        v0 = vcount8;
        send_frame(0, 32'hFF, 1'b0, 1'b1, 3, 11);
        chk("ff_data", 32'(b8.data_o), 32'hFF);
        tick();
        tick();
        chk("ff_pulses", 32'(vcount8 - v0), 32'h1);

        v0 = vcount8;
        send_frame(0, 32'h96, 1'b0, 1'b1, 1, 5);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_busy", 32'(b8.busy_o), 32'h0);
        chk("mid_data", 32'(b8.data_o), 32'h0);
        chk("mid_perr", 32'(b8.parity_err_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        idle(2);
        send_frame(0, 32'h12, 1'b0, 1'b1, 1, 11);
        chk("r12_data", 32'(b8.data_o), 32'h12);
        chk("r12_perr", 32'(b8.parity_err_o), 32'h0);
        tick();
        chk("r12_pulses", 32'(vcount8 - v0), 32'h1);

        send_frame(1, 32'h00, 1'b1, 1'b1, 0, 8);
        chk("odd_ok", 32'(b5.parity_err_o), 32'h0);
        send_frame(1, 32'h00, 1'b0, 1'b1, 0, 8);
        chk("odd_bad", 32'(b5.parity_err_o), 32'h1);
        chk("odd_data", 32'(b5.data_o), 32'h0);

        for (int n = 0; n < 60; n++) begin
            int   sel;
            logic stop;
            sel  = int'($urandom_range(1, 0));
            stop = ($urandom_range(3, 0) != 0);
            send_frame(sel, $urandom, 1'($urandom), stop, 2,
                       (sel == 0) ? 11 : 8);
            idle(int'($urandom_range(2, 0)));
        end
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
